// File: rtl/divider_if.sv
// divider_if: request/response bundle between the execute stage and the divider.
//   start       request a divide (sampled on the rising clock edge)
//   signed_div  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   operand_a   dividend; sampled with start
//   operand_b   divisor; sampled with start
//   cancel      pipeline flush; annuls the operation in flight
//   busy        operation in progress
//   ready       one-cycle pulse marking valid results
//   result_hi   remainder (register hi)
//   result_lo   quotient (register lo)
// master drives the request side; slave is the divider.
interface divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             cancel;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, signed_div, operand_a, operand_b, cancel,
        input  busy, ready, result_hi, result_lo
    );

    modport slave (
        input  start, signed_div, operand_a, operand_b, cancel,
        output busy, ready, result_hi, result_lo
    );
endinterface

// File: rtl/divider.sv
// divider: multi-cycle restoring divider for DIV / DIVU.
//   clock  rising-edge clock for all state
//   reset  synchronous, active-high; clears state and all datapath registers
//   bus    divider_if.slave: start/signed_div/operand_a/operand_b/cancel in,
//          busy/ready/result_hi (remainder)/result_lo (quotient) out
// A nonzero divide takes 32 shift-subtract steps on magnitudes; a zero divisor
// takes a two-cycle shortcut (lo = all ones, hi = dividend). Only WIDTH = 32
// is supported (6-bit step counter).
module divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ZERO,
        DONE
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [5:0]       count;
    logic [WIDTH-1:0] quo;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem;        // partial remainder
    logic [WIDTH-1:0] divisor;
    logic             neg_quo;
    logic             neg_rem;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    logic             accept;
    logic             divisor_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   step_partial;
    logic [WIDTH:0]   step_diff;
    logic             step_bit;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] final_quo;
    logic [WIDTH-1:0] final_rem;

    // Request decode and operand magnitudes.
    always_comb begin
        accept       = bus.start && !bus.cancel;
        divisor_zero = (bus.operand_b == '0);
        a_neg        = bus.signed_div && bus.operand_a[WIDTH-1];
        b_neg        = bus.signed_div && bus.operand_b[WIDTH-1];
        abs_a        = a_neg ? -bus.operand_a : bus.operand_a;
        abs_b        = b_neg ? -bus.operand_b : bus.operand_b;
    end

    // One restoring step. The partial remainder is always below twice the
    // divisor, so bit WIDTH of the 33-bit difference is a clean sign bit.
    always_comb begin
        step_partial = {rem, quo[WIDTH-1]};
        step_diff    = step_partial - {1'b0, divisor};
        step_bit     = ~step_diff[WIDTH];
        step_rem     = step_bit ? step_diff[WIDTH-1:0] : step_partial[WIDTH-1:0];
        step_quo     = {quo[WIDTH-2:0], step_bit};
        // Sign fix-up is folded into the final step so the corrected results
        // are already registered while the machine sits in DONE.
        final_quo    = neg_quo ? -step_quo : step_quo;
        final_rem    = neg_rem ? -step_rem : step_rem;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = divisor_zero ? ZERO : BUSY;
                end
            end
            BUSY: begin
                if (bus.cancel) begin
                    state_next = IDLE;
                end else if (count == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            ZERO: begin
                state_next = bus.cancel ? IDLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Results are written only on the edge that enters DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count   <= '0;
                        rem     <= '0;
                        divisor <= abs_b;
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        // The zero-divisor path reports the raw dividend.
                        quo     <= divisor_zero ? bus.operand_a : abs_a;
                    end
                end
                BUSY: begin
                    if (!bus.cancel) begin
                        rem   <= step_rem;
                        quo   <= step_quo;
                        count <= count + 6'd1;
                        if (count == LAST_STEP) begin
                            result_lo <= final_quo;
                            result_hi <= final_rem;
                        end
                    end
                end
                ZERO: begin
                    if (!bus.cancel) begin
                        result_lo <= '1;
                        result_hi <= quo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.ready     = (state == DONE) && !bus.cancel;
        bus.result_hi = result_hi;
        bus.result_lo = result_lo;
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider. Operations are compared against
// a plain-arithmetic reference (64-bit signed / unsigned division with the
// divide-by-zero rule), including latency, busy coverage, ready pulse width,
// cancel, reset priority and back-to-back starts.
module tb_divider;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] held_hi  = '0;
    logic [31:0] held_lo  = '0;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint la;
        longint lb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            q  = 32'(la / lb);
            r  = 32'(la % lb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Present a request for the edge N that follows; returns #1 after edge N.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.start      = 1'b1;
        bus.operand_a  = a;
        bus.operand_b  = b;
        bus.signed_div = s;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Full operation; caller is positioned at a negedge. Ends at the negedge
    // of the cycle after ready, where a back-to-back start may be presented.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input string name);
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic [31:0] got_lo;
        logic [31:0] got_hi;
        int          exp_lat;
        int          lat;
        int          busy_low;
        model(a, b, s, exp_lo, exp_hi);
        exp_lat  = (b == 32'd0) ? 2 : 33;
        lat      = 0;
        busy_low = 0;
        got_lo   = '0;
        got_hi   = '0;
        issue(a, b, s);
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clock);
            if (bus.busy !== 1'b1) busy_low++;
            if (bus.ready === 1'b1) begin
                lat    = i;
                got_lo = bus.result_lo;
                got_hi = bus.result_hi;
            end
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d (0 = no ready)", name, lat, exp_lat);
        end
        n_checks++;
        if (got_lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s lo: got %h expected %h", name, got_lo, exp_lo);
        end
        n_checks++;
        if (got_hi !== exp_hi) begin
            n_fail++;
            $display("FAIL %s hi: got %h expected %h", name, got_hi, exp_hi);
        end
        n_checks++;
        if (busy_low !== 0) begin
            n_fail++;
            $display("FAIL %s busy: low in %0d cycles expected 0", name, busy_low);
        end
        @(negedge clock);
        n_checks++;
        if ({bus.busy, bus.ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s after_ready busy/ready: got %b expected 00", name, {bus.busy, bus.ready});
        end
        n_checks++;
        if ({bus.result_hi, bus.result_lo} !== {exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL %s hold: got %h expected %h", name,
                     {bus.result_hi, bus.result_lo}, {exp_hi, exp_lo});
        end
        held_hi = exp_hi;
        held_lo = exp_lo;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.cancel     = 1'b0;
        bus.signed_div = 1'b0;
        bus.operand_a  = 32'd100;
        bus.operand_b  = 32'd7;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({bus.busy, bus.ready, bus.result_hi, bus.result_lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%b/%h/%h expected 0/0/0/0",
                     bus.busy, bus.ready, bus.result_hi, bus.result_lo);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_directed();
        run_op(32'd100, 32'd7, 1'b0, "udiv_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_overflow");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "udiv_max_1");
        run_op(32'h0000_1234, 32'd0, 1'b0, "udiv_zero");
        run_op(32'hF000_0000, 32'd0, 1'b1, "sdiv_zero");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
        run_op(32'd5, 32'hFFFF_FFFF, 1'b0, "udiv_small_big");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1;
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'd1000, 32'd10, 1'b0, "b2b_first");
        run_op(32'hFFFF_FC18, 32'd10, 1'b1, "b2b_second");
        run_op(32'd77, 32'd0, 1'b1, "b2b_zero");
        run_op(32'd77, 32'd8, 1'b0, "b2b_after_zero");
    endtask

    task automatic test_start_ignored();
        logic [31:0] got_lo;
        logic [31:0] got_hi;
        int          lat;
        lat    = 0;
        got_lo = '0;
        got_hi = '0;
        issue(32'd100, 32'd7, 1'b0);
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clock);
            if (bus.ready === 1'b1) begin
                lat    = i;
                got_lo = bus.result_lo;
                got_hi = bus.result_hi;
            end
            if (i == 5) begin
                bus.start     = 1'b1;
                bus.operand_a = 32'd9;
                bus.operand_b = 32'd3;
            end
            if (i == 12) bus.start = 1'b0;
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL ignore_start latency: got %0d expected 33", lat);
        end
        n_checks++;
        if ({got_hi, got_lo} !== {32'd2, 32'd14}) begin
            n_fail++;
            $display("FAIL ignore_start result: got %h expected %h", {got_hi, got_lo}, {32'd2, 32'd14});
        end
        @(negedge clock);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start idle busy: got %b expected 0", bus.busy);
        end
        held_hi = 32'd2;
        held_lo = 32'd14;
    endtask

    task automatic test_cancel();
        int ready_seen;
        // Cancel in BUSY at step 10.
        issue(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clock);
        bus.cancel = 1'b1;
        @(posedge clock);
        #1;
        bus.cancel = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({bus.busy, bus.ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL cancel_busy state: got %b expected 00", {bus.busy, bus.ready});
        end
        n_checks++;
        if ({bus.result_hi, bus.result_lo} !== {held_hi, held_lo}) begin
            n_fail++;
            $display("FAIL cancel_busy hold: got %h expected %h",
                     {bus.result_hi, bus.result_lo}, {held_hi, held_lo});
        end
        run_op(32'd9, 32'd3, 1'b0, "after_cancel_9_3");

        // Cancel in ZERO.
        issue(32'h55, 32'd0, 1'b1);
        @(negedge clock);
        bus.cancel = 1'b1;
        @(posedge clock);
        #1;
        bus.cancel = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.ready === 1'b1 || bus.busy === 1'b1) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0) begin
            n_fail++;
            $display("FAIL cancel_zero activity: got %0d busy/ready cycles expected 0", ready_seen);
        end
        n_checks++;
        if ({bus.result_hi, bus.result_lo} !== {held_hi, held_lo}) begin
            n_fail++;
            $display("FAIL cancel_zero hold: got %h expected %h",
                     {bus.result_hi, bus.result_lo}, {held_hi, held_lo});
        end

        // Cancel in DONE: ready suppressed, results already taken on entry.
        issue(32'hAB, 32'd0, 1'b0);
        repeat (2) @(negedge clock);
        bus.cancel = 1'b1;
        #1;
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_done ready: got %b expected 0", bus.ready);
        end
        held_hi = 32'hAB;
        held_lo = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        bus.cancel = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({bus.busy, bus.ready, bus.result_hi, bus.result_lo} !== {2'b00, held_hi, held_lo}) begin
            n_fail++;
            $display("FAIL cancel_done after: got %b/%b/%h/%h expected 0/0/%h/%h",
                     bus.busy, bus.ready, bus.result_hi, bus.result_lo, held_hi, held_lo);
        end

        // Start and cancel together in IDLE: nothing starts.
        bus.start      = 1'b1;
        bus.cancel     = 1'b1;
        bus.operand_a  = 32'd50;
        bus.operand_b  = 32'd5;
        bus.signed_div = 1'b0;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cancel_idle busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        int ready_seen;
        issue(32'd100, 32'd7, 1'b0);
        repeat (20) @(negedge clock);
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd3;
        @(posedge clock);
        #1;
        n_checks++;
        if ({bus.busy, bus.ready, bus.result_hi, bus.result_lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %b/%b/%h/%h expected 0/0/0/0",
                     bus.busy, bus.ready, bus.result_hi, bus.result_lo);
        end
        @(posedge clock);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.ready === 1'b1 || bus.busy === 1'b1) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid activity: got %0d busy/ready cycles expected 0", ready_seen);
        end
        held_hi = '0;
        held_lo = '0;
        n_checks++;
        if ({bus.result_hi, bus.result_lo} !== {held_hi, held_lo}) begin
            n_fail++;
            $display("FAIL reset_mid results: got %h expected %h",
                     {bus.result_hi, bus.result_lo}, {held_hi, held_lo});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_cancel();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
